// File: rtl/dma_bus_seq.sv
// rtl/dma_bus_seq.sv - DMA bus-master sequencer and address counter (ACR)
//
// Purpose: arbitrates for the host bus and runs longword transfer cycles at
// the ACR address. Each completed longword is handshaken with the FIFO.
//
// Ports:
//   CLK, CLR_DMAENA            clock; async active-high clear (also clears DMAENA)
//   DMAENA, DMADIR             DMA enable / direction (1 = memory read)
//   ACR_WR_H, ACR_WR_L, MID    CPU writes of ACR upper/lower halves
//   FIFO_RDY                   FIFO can source/sink one longword
//   BG, XFER_DONE, BERR        bus grant and cycle terminations
//   ACR_O                      current longword address
//   BR, BGACK, CYC, RW         bus request / ownership / cycle / direction
//   FIFO_ACK                   one pulse per completed longword
//   DMA_ERR                    sticky bus-error flag
module dma_bus_seq #(
  parameter int BURST_MAX = 8
) (
  input  logic        CLK,
  input  logic        CLR_DMAENA,
  input  logic        DMAENA,
  input  logic        DMADIR,
  input  logic        ACR_WR_H,
  input  logic        ACR_WR_L,
  input  logic [15:0] MID,
  input  logic        FIFO_RDY,
  input  logic        BG,
  input  logic        XFER_DONE,
  input  logic        BERR,
  output logic [31:0] ACR_O,
  output logic        BR,
  output logic        BGACK,
  output logic        CYC,
  output logic        RW,
  output logic        FIFO_ACK,
  output logic        DMA_ERR
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_OWN,
    S_CYCLE,
    S_RELEASE
  } state_t;

  localparam logic [7:0] BURST_LIM = 8'(BURST_MAX);

  state_t      state;
  state_t      state_nxt;
  logic [29:0] acr_q;        // longword address; byte bits are always zero
  logic [7:0]  burst_cnt;
  logic [7:0]  burst_inc;
  logic        req_go;
  logic        done_ok;
  logic        berr_hit;
  logic        in_idle;
  logic        unused_mid_lo;

  assign unused_mid_lo = ^MID[1:0];

  assign in_idle   = (state == S_IDLE);
  assign req_go    = DMAENA & FIFO_RDY & ~DMA_ERR;
  // BERR has priority over a simultaneous XFER_DONE
  assign berr_hit  = (state == S_CYCLE) & BERR;
  assign done_ok   = (state == S_CYCLE) & XFER_DONE & ~BERR;
  assign burst_inc = burst_cnt + 8'd1;

  assign ACR_O = {acr_q, 2'b00};

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req_go) state_nxt = S_REQ;
      end
      S_REQ: begin
        if (BG)           state_nxt = S_OWN;
        else if (!DMAENA) state_nxt = S_IDLE;
      end
      S_OWN: begin
        if (FIFO_RDY && DMAENA) state_nxt = S_CYCLE;
        else                    state_nxt = S_RELEASE;
      end
      S_CYCLE: begin
        // A DMAENA drop is not checked here: the cycle always completes
        if (BERR)           state_nxt = S_RELEASE;
        else if (XFER_DONE) state_nxt = (burst_inc < BURST_LIM) ? S_OWN : S_RELEASE;
      end
      S_RELEASE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs are flops loaded from the next state so they change with the state
  always_ff @(posedge CLK or posedge CLR_DMAENA) begin
    if (CLR_DMAENA) begin
      state     <= S_IDLE;
      acr_q     <= '0;
      burst_cnt <= '0;
      BR        <= 1'b0;
      BGACK     <= 1'b0;
      CYC       <= 1'b0;
      RW        <= 1'b0;
      FIFO_ACK  <= 1'b0;
      DMA_ERR   <= 1'b0;
    end else begin
      state    <= state_nxt;
      BR       <= (state_nxt == S_REQ);
      BGACK    <= (state_nxt == S_OWN) || (state_nxt == S_CYCLE);
      CYC      <= (state_nxt == S_CYCLE);
      RW       <= (state_nxt == S_CYCLE) && DMADIR;
      FIFO_ACK <= done_ok;

      if (berr_hit) DMA_ERR <= 1'b1;

      // CPU writes only land in IDLE, where no increment can occur
      if (in_idle && ACR_WR_H) acr_q[29:14] <= MID;
      if (in_idle && ACR_WR_L) acr_q[13:0]  <= MID[15:2];
      if (done_ok)             acr_q        <= acr_q + 30'd1;

      if (in_idle && (state_nxt == S_REQ)) burst_cnt <= '0;
      else if (done_ok)                    burst_cnt <= burst_inc;
    end
  end

endmodule

// File: doc/dma_bus_seq.md
# dma_bus_seq

DMA bus-master sequencer and address counter (ACR) for the SCSI DMA path. It sits directly downstream of the control register block and consumes its `DMAENA`/`DMADIR` outputs. It arbitrates for the host bus, drives longword transfer cycles at the ACR address, and handshakes each completed longword with the FIFO. All state is cleared whenever DMA is stopped or the chip is reset.

## Interface
- `BURST_MAX`, default 8: maximum longword transfers per bus tenure (1..255).
- `CLK`  in  1  system clock; all flops on rising edge.
- `CLR_DMAENA`  in  1  reset, asynchronous, active-high; it is the same net that clears `DMAENA`.
- `DMAENA`  in  1  DMA enabled (control register bit 8).
- `DMADIR`  in  1  1 = memory read (to SCSI), 0 = memory write (from SCSI).
- `ACR_WR_H`, `ACR_WR_L`  in  1 each  write strobes for the ACR upper and lower halves.
- `MID`  in  16  CPU write data.
- `FIFO_RDY`  in  1  for reads, FIFO has space for one longword; for writes, FIFO holds one longword.
- `BG`  in  1  bus grant.
- `XFER_DONE`  in  1  current bus cycle terminated normally (single-cycle pulse).
- `BERR`  in  1  current bus cycle terminated with error.
- `ACR_O`  out  32  current address; bits [1:0] are always 0.
- `BR`  out  1  bus request.
- `BGACK`  out  1  bus owned.
- `CYC`  out  1  transfer cycle active; address is valid on `ACR_O`.
- `RW`  out  1  equals `DMADIR` whenever `CYC` = 1; 0 otherwise.
- `FIFO_ACK`  out  1  one-cycle pulse per completed longword.
- `DMA_ERR`  out  1  sticky bus-error flag.

## Operation
- The ACR is 32 bits.
  - `ACR_WR_H` loads [31:16] from `MID`.
  - `ACR_WR_L` loads [15:2] from `MID[15:2]`; [1:0] are forced to 0.
- ACR writes take effect only in IDLE. They are ignored in every other state.
- ACR increments by 4 on each `XFER_DONE`. It wraps from 0xFFFFFFFC to 0x00000000 with the carry discarded.
- Burst counter: 8 bits. It is cleared on entry to REQ and incremented on each `XFER_DONE`.
- States: IDLE, REQ, OWN, CYCLE, RELEASE.
- IDLE → REQ when `DMAENA` & `FIFO_RDY` & ~`DMA_ERR`.
- REQ (`BR`=1):
  - → OWN when `BG`=1.
  - → IDLE if `DMAENA` falls before a grant.
- OWN (`BGACK`=1, `BR`=0):
  - → CYCLE when `FIFO_RDY` & `DMAENA`.
  - Otherwise → RELEASE.
- CYCLE (`BGACK`=1, `CYC`=1), wait for termination:
  - `XFER_DONE` → pulse `FIFO_ACK`, increment ACR and burst counter. Then → OWN if the burst count is < `BURST_MAX`, else → RELEASE.
  - `BERR` → set `DMA_ERR`, ACR unchanged, no `FIFO_ACK`, → RELEASE.
  - `XFER_DONE` and `BERR` in the same cycle → `BERR` wins.
  - A `DMAENA` drop inside CYCLE does not abort the cycle. The cycle completes, then OWN releases.
- RELEASE: all outputs idle for one cycle, then → IDLE.
- `DMA_ERR` blocks new requests and is cleared only by `CLR_DMAENA`.
- `CLR_DMAENA` asserted in any state immediately applies the reset values below and forces IDLE, including mid-cycle.

## Timing
- Reset values: `ACR_O`=0, `BR`=0, `BGACK`=0, `CYC`=0, `RW`=0, `FIFO_ACK`=0, `DMA_ERR`=0, burst counter=0, state=IDLE.
- All outputs are registered.
- `BR` rises 1 clock after the IDLE condition is met.
- `BGACK` rises 1 clock after `BG` is sampled high.
- `CYC` rises 1 clock after entering OWN, when `FIFO_RDY`=1.
- `FIFO_ACK` and the new `ACR_O` both appear the clock after `XFER_DONE`.
- Minimum spacing between cycles is 2 clocks: the CYCLE → OWN → CYCLE path guarantees one dead clock between cycles.
- RELEASE → IDLE → REQ: at least 2 clocks with `BR`=0 between tenures.
- ACR writes are single-clock strobes. A write arriving in the same clock as the IDLE → REQ transition is accepted, because the state is still IDLE at that edge.

## Test plan
- Reset, then write ACR H=0x0012 and L=0x3457, then set `DMAENA`, `FIFO_RDY`, and `BG` → `ACR_O`=0x00123454; `BR` then `BGACK`; 8 cycles each terminated by `XFER_DONE`; final `ACR_O`=0x00123474; RELEASE, then a new `BR`.
- ACR=0xFFFFFFF8, 3 transfers → ACR_O sequence FFFFFFF8, FFFFFFFC, 00000000, 00000004.
- `BERR` on the 2nd cycle with ACR starting at 0x1000 → `DMA_ERR`=1, ACR_O=0x1004, a single `FIFO_ACK`, and no further `BR` until `CLR_DMAENA` pulses.
- `FIFO_RDY` drops after 3 transfers → OWN → RELEASE, `BGACK` low; `FIFO_RDY` high again → new request, burst counter restarts at 0.
- `CLR_DMAENA` pulse during CYCLE → `CYC`, `BGACK`, `ACR_O`, and `DMA_ERR` are all 0 immediately, without waiting for a clock edge.
- ACR write during OWN/CYCLE → ignored; ACR continues incrementing from its prior value.
